// File: rtl/ad5683_dac_writer.sv
// rtl/ad5683_dac_writer.sv - AD5683 24-bit SPI frame writer for TCXO tuning codes
// Optional power-up control frame, optional duplicate-code suppression.
module ad5683_dac_writer #(
    parameter int          CLK_DIV   = 4,
    parameter int          SYNC_GAP  = 4,
    parameter bit          INIT_CTRL = 1'b1,
    parameter logic [15:0] CTRL_WORD = 16'h0000,
    parameter bit          SKIP_SAME = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        busy,
    output logic        init_done,
    output logic        sclk,
    output logic        mosi,
    output logic        sync_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SYNC_GAP - 1);
    localparam logic [4:0]       NBITS   = 5'd24;
    localparam logic [23:0]      CTRL_FRAME = {4'b0100, CTRL_WORD, 4'b0000};

    typedef enum logic [1:0] {RST_WAIT, IDLE, SHIFT, GAP} state_t;

    state_t            state;
    logic [22:0]       shreg;
    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              init_pend;
    logic [15:0]       last_code;
    logic              last_valid;
    logic [23:0]       data_frame;
    logic              dup_code;

    assign data_frame = {4'b0011, in_data, 4'b0000};
    assign dup_code   = SKIP_SAME && last_valid && (in_data == last_code);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RST_WAIT;
            shreg      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            init_pend  <= 1'b0;
            last_code  <= '0;
            last_valid <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            sclk       <= 1'b1;
            mosi       <= 1'b0;
            sync_n     <= 1'b1;
        end else begin
            case (state)
                RST_WAIT: begin
                    if (INIT_CTRL) begin
                        shreg     <= CTRL_FRAME[22:0];
                        mosi      <= CTRL_FRAME[23];
                        sync_n    <= 1'b0;
                        busy      <= 1'b1;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        init_pend <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        init_done <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                IDLE: begin
                    // A duplicate code is consumed here without leaving IDLE.
                    if (in_valid && in_ready && !dup_code) begin
                        shreg      <= data_frame[22:0];
                        mosi       <= data_frame[23];
                        last_code  <= in_data;
                        last_valid <= 1'b1;
                        sync_n     <= 1'b0;
                        busy       <= 1'b1;
                        in_ready   <= 1'b0;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_MAX) begin
                        div_cnt <= '0;
                        if (sclk) begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + 5'd1;
                        end else if (bit_cnt == NBITS) begin
                            sclk    <= 1'b1;
                            sync_n  <= 1'b1;
                            mosi    <= 1'b0;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            // Next bit changes on the rising edge, half a period before the DAC samples it.
                            sclk  <= 1'b1;
                            mosi  <= shreg[22];
                            shreg <= {shreg[21:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_MAX) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        if (init_pend) begin
                            init_done <= 1'b1;
                            init_pend <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: state <= RST_WAIT;
            endcase
        end
    end

endmodule

// File: doc/ad5683_dac_writer.md
Name: ad5683_dac_writer

Overview:
- Serialises 16-bit DAC codes from the reference-PLL loop into AD5683 24-bit SPI write frames. It drives the TCXO tuning DAC.
- Sits directly downstream of the PLL phase/frequency accumulator, which presents each new code over a valid/ready handshake.
- Optionally sends one control-register frame after reset.
- Optionally suppresses frames whose code matches the last one written.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal values ≥1.
- SYNC_GAP, 4: clk cycles sync_n is held high between frames; legal values ≥1.
- INIT_CTRL, 1: 1 = send a control frame once after reset, before accepting codes.
- CTRL_WORD, 16'h0000: value for frame bits DB19..DB4 of the control frame. Bit 15 = DB19 reset, 14:13 = PD, 12 = REF, 11 = GAIN, 10 = DCEN, rest 0.
- SKIP_SAME, 1: 1 = accept but do not transmit a code equal to the last transmitted code.

Ports:
- clk, input, 1: single clock for all logic.
- reset, input, 1: asynchronous, active-high reset.
- in_data, input, 16: DAC code.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: block can accept a code this cycle.
- busy, output, 1: frame or SYNC gap in progress.
- init_done, output, 1: control frame complete, or INIT_CTRL=0.
- sclk, output, 1: SPI clock to the AD5683.
- mosi, output, 1: SPI data, MSB first.
- sync_n, output, 1: AD5683 SYNC, active low.

Behaviour:
- Reset is asynchronous. While asserted and after it is released:
  - Outputs: sclk=1, sync_n=1, mosi=0, busy=0, in_ready=0, init_done=0.
  - last_valid=0; shift register and counters are zeroed.
- States: RST_WAIT, IDLE, SHIFT, GAP.
- RST_WAIT lasts one cycle after reset release.
  - INIT_CTRL=1: load frame {4'b0100, CTRL_WORD, 4'b0000} and go to SHIFT, with init pending.
  - INIT_CTRL=0: set init_done=1 and go to IDLE.
- IDLE:
  - in_ready=1 and busy=0.
  - On in_valid & in_ready, the code is accepted.
  - If SKIP_SAME=1, last_valid=1 and in_data==last_code: stay in IDLE, no frame, in_ready stays 1.
  - Otherwise: load frame {4'b0011, in_data, 4'b0000}, set last_code=in_data and last_valid=1, go to SHIFT.
- in_ready is 0 in every state except IDLE. Codes are not buffered; the upstream stage holds its data until accepted.
- SHIFT, with H=CLK_DIV and cycle 0 = the first SHIFT cycle:
  - sync_n=0 from cycle 0. mosi=bit23 at cycle 0.
  - sclk falls at cycles H, 3H, …, 47H. These are the 24 falling edges; the DAC samples on them.
  - sclk rises at cycles 2H, 4H, …, 48H.
  - mosi advances to the next bit on rising edges 2H..46H, so each bit is stable for a full half-period around its falling edge.
  - At cycle 48H: sclk=1, sync_n=1, mosi=0, go to GAP.
  - The bit counter is 5 bits and counts 24 falling edges. The divider counter is wide enough for CLK_DIV-1 and wraps to 0 at each sclk toggle.
- GAP:
  - sync_n=1 for SYNC_GAP cycles, then go to IDLE.
  - If this was the init frame, init_done goes to 1 on GAP exit.
- Frame timing: sync_n falls on the cycle after acceptance. Total time from acceptance to in_ready=1 is 48·CLK_DIV + SYNC_GAP + 1 cycles.
- busy=1 in SHIFT and GAP, and 0 otherwise.
- The init frame does not update last_code or last_valid.
- in_valid held high while in_ready=0 has no effect. A new code during a frame waits; it is never dropped or merged.
- Reset asserted mid-frame:
  - Asynchronously forces sync_n=1 and sclk=1, which aborts the partial frame. The AD5683 ignores frames of fewer than 24 bits.
  - After release the block re-runs RST_WAIT, including the init frame if INIT_CTRL=1.
- An in_data change while in_valid=0 is ignored.

Test Plan:
- Power-up, CLK_DIV=2, SYNC_GAP=3, INIT_CTRL=1, CTRL_WORD=16'h0000:
  - Captured frame = 24'h400000, exactly 24 falling edges.
  - init_done rises 2·48+3 = 99 cycles after the first SHIFT cycle.
  - in_ready stays 0 until then.
- Write in_data=16'h8000, then 16'h7FFF:
  - Frames 24'h380000 and 24'h37FFF0.
  - sync_n falls the cycle after acceptance and is high ≥3 cycles between frames.
  - mosi is constant across every falling edge.
- SKIP_SAME=1, write 16'h1234 twice:
  - One frame 24'h312340.
  - The second accept returns to in_ready=1 the next cycle with no sync_n activity.
  - A following write of 16'h1235 transmits.
- Upstream holds in_valid=1 with 16'hABCD during a frame:
  - Accepted only when in_ready returns.
  - Exactly one frame 24'h3ABCD0; no extra frames.
- Reset pulse at falling edge 10 of a frame:
  - sync_n=1 and sclk=1 within the same cycle (asynchronous).
  - After release, the init frame 24'h400000 is resent, then normal operation.
- CLK_DIV=1, INIT_CTRL=0, SKIP_SAME=0, write 16'hFFFF twice:
  - Two frames 24'h3FFFF0, each 48 cycles of sync_n low.
  - init_done=1 from the second cycle after reset release.
